// File: rtl/ssd_sniffer_if.sv
// Display-side bundle: scanner-driven anode/cathode lines plus the sniffer's recovered outputs.
interface ssd_sniffer_if;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] hex;
  logic [3:0]  valid;
  logic        frame_done;
  logic        err;

  modport master (
    output an,
    output seg,
    input  hex,
    input  valid,
    input  frame_done,
    input  err
  );

  modport slave (
    input  an,
    input  seg,
    output hex,
    output valid,
    output frame_done,
    output err
  );
endinterface

// File: rtl/ssd_sniffer.sv
// Seven-segment capture monitor: settles each digit slot, decodes it back to hex, tracks frames.
// Optional decimal-point capture is enabled by defining SSD_SNIFF_DP_EN.
module ssd_sniffer #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef SSD_SNIFF_DP_EN
  input  logic       dp,
  output logic [3:0] dp_out,
`endif
  ssd_sniffer_if.slave bus
);

`ifdef SSD_SNIFF_DP_EN
  localparam int unsigned W = 12;
`else
  localparam int unsigned W = 11;
`endif
  localparam logic [7:0] CntLast = 8'(STABLE_CYCLES - 1);

  typedef enum logic {StSettle, StHold} state_e;

  state_e         state_q, state_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [W-1:0]   raw, s1_q, s2_q, p_q;
  logic [15:0]    hex_q, hex_d;
  logic [3:0]     valid_q, valid_d, mask_q, mask_d, mask_next;
  logic           fd_q, fd_d, err_q, err_d;
  logic           capture;
  logic [3:0]     sel;
  logic           one_low;
  logic [1:0]     idx;
  logic [4:0]     dec;

`ifdef SSD_SNIFF_DP_EN
  logic [3:0] dp_out_q, dp_out_d;
  assign raw    = {dp, bus.an, bus.seg};
  assign dp_out = dp_out_q;
`else
  assign raw = {bus.an, bus.seg};
`endif

  // Returns {hit, value}; hit=0 for blank and unrecognized patterns.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h40:   decode = {1'b1, 4'h0};
      7'h79:   decode = {1'b1, 4'h1};
      7'h24:   decode = {1'b1, 4'h2};
      7'h30:   decode = {1'b1, 4'h3};
      7'h19:   decode = {1'b1, 4'h4};
      7'h12:   decode = {1'b1, 4'h5};
      7'h02:   decode = {1'b1, 4'h6};
      7'h78:   decode = {1'b1, 4'h7};
      7'h00:   decode = {1'b1, 4'h8};
      7'h10:   decode = {1'b1, 4'h9};
      7'h08:   decode = {1'b1, 4'hA};
      7'h03:   decode = {1'b1, 4'hB};
      7'h46:   decode = {1'b1, 4'hC};
      7'h21:   decode = {1'b1, 4'hD};
      7'h06:   decode = {1'b1, 4'hE};
      7'h0E:   decode = {1'b1, 4'hF};
      default: decode = 5'b0;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    // Any change in the compared lines restarts settling, whatever the state.
    if (s2_q != p_q) begin
      cnt_d   = 8'd0;
      state_d = StSettle;
    end else if (state_q == StSettle) begin
      if (cnt_q == CntLast) begin
        capture = 1'b1;
        state_d = StHold;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  assign sel     = ~p_q[10:7];
  assign one_low = (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0);
  assign dec     = decode(p_q[6:0]);

  always_comb begin
    idx = 2'd0;
    unique case (sel)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
  end

  always_comb begin
    hex_d     = hex_q;
    valid_d   = valid_q;
    mask_d    = mask_q;
    mask_next = mask_q | sel;
    fd_d      = 1'b0;
    err_d     = 1'b0;
`ifdef SSD_SNIFF_DP_EN
    dp_out_d  = dp_out_q;
`endif
    if (capture && one_low) begin
      if (dec[4]) begin
        hex_d[{idx, 2'b00} +: 4] = dec[3:0];
        valid_d[idx]             = 1'b1;
      end else begin
        valid_d[idx] = 1'b0;
        err_d        = (p_q[6:0] != 7'h7F);
      end
      if (mask_next == 4'hF) begin
        fd_d   = 1'b1;
        mask_d = 4'd0;
      end else begin
        mask_d = mask_next;
      end
`ifdef SSD_SNIFF_DP_EN
      dp_out_d[idx] = ~p_q[11];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StSettle;
      cnt_q    <= 8'd0;
      s1_q     <= '1;
      s2_q     <= '1;
      p_q      <= '1;
      hex_q    <= 16'd0;
      valid_q  <= 4'd0;
      mask_q   <= 4'd0;
      fd_q     <= 1'b0;
      err_q    <= 1'b0;
`ifdef SSD_SNIFF_DP_EN
      dp_out_q <= 4'd0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      s1_q     <= raw;
      s2_q     <= s1_q;
      p_q      <= s2_q;
      hex_q    <= hex_d;
      valid_q  <= valid_d;
      mask_q   <= mask_d;
      fd_q     <= fd_d;
      err_q    <= err_d;
`ifdef SSD_SNIFF_DP_EN
      dp_out_q <= dp_out_d;
`endif
    end
  end

  assign bus.hex        = hex_q;
  assign bus.valid      = valid_q;
  assign bus.frame_done = fd_q;
  assign bus.err        = err_q;

endmodule
